// File: rtl/outbuff_seq_pack.sv
// Shared state encoding and default widths for the output-buffer reconfiguration sequencer.
package outbuff_seq_pack;

  localparam int OUTBUFF_N_SEL    = 4;
  localparam int OUTBUFF_N_DIV    = 3;
  localparam int OUTBUFF_N_WAIT   = 8;
  localparam int OUTBUFF_WIN_LOG2 = 10;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    SWITCH,
    SETTLE,
    MEAS
  } outbuff_seq_state_t;

endpackage

// File: rtl/outbuff_edge_cnt.sv
// Synchronizes mon_clk into clk, detects rising edges and counts them with saturation.
// Detection latency is 3 clk cycles (two sync flops plus the edge-detect flop).
module outbuff_edge_cnt #(
  parameter int WIN_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                mon_clk,
  input  logic                clr,
  input  logic                cnt_en,
  output logic [WIN_LOG2-1:0] count
);

  logic sync1, sync2, prev;
  logic rise;

  assign rise = sync2 & ~prev;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= mon_clk;
      sync2 <= sync1;
      prev  <= sync2;
      if (clr) begin
        count <= '0;
      end else if (cnt_en && rise && (count != '1)) begin
        count <= count + WIN_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/outbuff_seq.sv
// Sequences sel/ndiv/en changes to the output buffer as gate, switch, settle, re-enable.
// OUTBUFF_SEQ_FREQ_CHECK_EN adds a MEAS state that counts mon_clk edges over 2^WIN_LOG2 cycles.
module outbuff_seq
  import outbuff_seq_pack::*;
#(
  parameter int N_SEL    = OUTBUFF_N_SEL,
  parameter int N_DIV    = OUTBUFF_N_DIV,
  parameter int N_WAIT   = OUTBUFF_N_WAIT,
  parameter int WIN_LOG2 = OUTBUFF_WIN_LOG2
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N_SEL-1:0]    req_sel,
  input  logic [N_DIV-1:0]    req_ndiv,
  input  logic                req_en,
  input  logic [N_WAIT-1:0]   settle_cycles,
  input  logic                mon_clk,
  output logic [N_SEL-1:0]    sel_outbuff,
  output logic [N_DIV-1:0]    ndiv_outbuff,
  output logic                en_outbuff,
  output logic                busy,
  output logic                done,
  output logic [WIN_LOG2-1:0] edge_cnt,
  output logic                cnt_valid
);

  outbuff_seq_state_t state, state_n;

  logic [N_WAIT-1:0] wait_cnt, wait_n;
  logic [N_WAIT-1:0] s_m1, s_m1_n;
  logic [N_SEL-1:0]  lat_sel, lat_sel_n, sel_n;
  logic [N_DIV-1:0]  lat_ndiv, lat_ndiv_n, ndiv_n;
  logic              lat_en, lat_en_n, en_n, done_n;

`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
  logic [WIN_LOG2-1:0] win_cnt, win_n, edge_n, count;
  logic                cnt_valid_n, clr, cnt_en;

  outbuff_edge_cnt #(.WIN_LOG2(WIN_LOG2)) u_edge_cnt (
    .clk     (clk),
    .rstb    (rstb),
    .mon_clk (mon_clk),
    .clr     (clr),
    .cnt_en  (cnt_en),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      win_cnt   <= '0;
      edge_cnt  <= '0;
      cnt_valid <= 1'b0;
    end else begin
      win_cnt   <= win_n;
      edge_cnt  <= edge_n;
      cnt_valid <= cnt_valid_n;
    end
  end
`else
  wire unused_mon_clk = mon_clk;
  assign edge_cnt  = '0;
  assign cnt_valid = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      s_m1         <= '0;
      lat_sel      <= '0;
      lat_ndiv     <= '0;
      lat_en       <= 1'b0;
      sel_outbuff  <= '0;
      ndiv_outbuff <= '0;
      en_outbuff   <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_n;
      s_m1         <= s_m1_n;
      lat_sel      <= lat_sel_n;
      lat_ndiv     <= lat_ndiv_n;
      lat_en       <= lat_en_n;
      sel_outbuff  <= sel_n;
      ndiv_outbuff <= ndiv_n;
      en_outbuff   <= en_n;
      done         <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_n     = wait_cnt;
    s_m1_n     = s_m1;
    lat_sel_n  = lat_sel;
    lat_ndiv_n = lat_ndiv;
    lat_en_n   = lat_en;
    sel_n      = sel_outbuff;
    ndiv_n     = ndiv_outbuff;
    en_n       = en_outbuff;
    done_n     = 1'b0;
`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
    win_n       = win_cnt;
    edge_n      = edge_cnt;
    cnt_valid_n = 1'b0;
    clr         = 1'b0;
    cnt_en      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          // A zero settle count still gates for one cycle.
          s_m1_n     = (settle_cycles == '0) ? '0 : settle_cycles - N_WAIT'(1);
          wait_n     = (settle_cycles == '0) ? '0 : settle_cycles - N_WAIT'(1);
          lat_sel_n  = req_sel;
          lat_ndiv_n = req_ndiv;
          lat_en_n   = req_en;
          en_n       = 1'b0;
          state_n    = GATE;
        end
      end
      GATE: begin
        if (wait_cnt == '0) state_n = SWITCH;
        else                wait_n  = wait_cnt - N_WAIT'(1);
      end
      SWITCH: begin
        sel_n  = lat_sel;
        ndiv_n = lat_ndiv;
        if (lat_en) begin
          wait_n  = s_m1;
          state_n = SETTLE;
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      SETTLE: begin
        if (wait_cnt == '0) begin
          en_n = 1'b1;
`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
          clr     = 1'b1;
          win_n   = '0;
          state_n = MEAS;
`else
          done_n  = 1'b1;
          state_n = IDLE;
`endif
        end else begin
          wait_n = wait_cnt - N_WAIT'(1);
        end
      end
`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
      MEAS: begin
        cnt_en = 1'b1;
        win_n  = win_cnt + WIN_LOG2'(1);
        if (win_cnt == '1) begin
          edge_n      = count;
          cnt_valid_n = 1'b1;
          done_n      = 1'b1;
          state_n     = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_outbuff_seq.sv
// Self-checking bench for outbuff_seq: hand-computed vector table, corner sequences and a randomized timeline model.
module tb_outbuff_seq;

`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
  localparam int MEAS_LEN = 1024;
  localparam bit FREQ     = 1'b1;
`else
  localparam int MEAS_LEN = 0;
  localparam bit FREQ     = 1'b0;
`endif

  logic       clk, rstb, req_valid, req_ready, req_en, mon_clk;
  logic [3:0] req_sel, sel_outbuff;
  logic [2:0] req_ndiv, ndiv_outbuff;
  logic [7:0] settle_cycles;
  logic       en_outbuff, busy, done, cnt_valid;
  logic [9:0] edge_cnt;

  int n_vec, n_bad;
  int cur_sel, cur_ndiv, cur_en;
  int exp_lo, exp_hi;
  bit mon_run;

  outbuff_seq dut (
    .clk           (clk),
    .rstb          (rstb),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_ndiv      (req_ndiv),
    .req_en        (req_en),
    .settle_cycles (settle_cycles),
    .mon_clk       (mon_clk),
    .sel_outbuff   (sel_outbuff),
    .ndiv_outbuff  (ndiv_outbuff),
    .en_outbuff    (en_outbuff),
    .busy          (busy),
    .done          (done),
    .edge_cnt      (edge_cnt),
    .cnt_valid     (cnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk/8 monitor clock with a phase unrelated to clk edges
  initial begin
    mon_clk = 1'b0;
    forever begin
      #40;
      mon_clk = mon_run ? ~mon_clk : 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] sel;
    logic [2:0] ndiv;
    logic       en;
    logic [7:0] settle;
    int         sel_at;
    int         en_at;
    int         done_at;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},  int'(sel_outbuff),  0);
    chk({tag, "_ndiv"}, int'(ndiv_outbuff), 0);
    chk({tag, "_en"},   int'(en_outbuff),   0);
    chk({tag, "_busy"}, int'(busy),         0);
    chk({tag, "_done"}, int'(done),         0);
    chk({tag, "_cnt"},  int'(edge_cnt),     0);
    chk({tag, "_cv"},   int'(cnt_valid),    0);
  endtask

  // Apply one request and compare every cycle against the expected timeline.
  // inj_t >= 0 drives a competing request (sel=5) at that offset; abort_t >= 0 resets there.
  task automatic do_req(input logic [3:0] s, input logic [2:0] nd, input logic e,
                        input logic [7:0] st, input int sel_at, input int en_at,
                        input int done_at, input int inj_t, input int abort_t);
    int d;
    d = done_at + (e ? MEAS_LEN : 0);
    @(negedge clk);
    chk("ready_pre", int'(req_ready), 1);
    req_sel = s; req_ndiv = nd; req_en = e; settle_cycles = st; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int t = 0; t <= d + 1; t++) begin
      @(negedge clk);
      if (inj_t >= 0 && t == inj_t + 1) req_valid = 1'b0;
      chk("sel",   int'(sel_outbuff),  (t >= sel_at) ? int'(s)  : cur_sel);
      chk("ndiv",  int'(ndiv_outbuff), (t >= sel_at) ? int'(nd) : cur_ndiv);
      chk("en",    int'(en_outbuff),   (en_at >= 0 && t >= en_at) ? 1 : 0);
      chk("busy",  int'(busy),         (t < d) ? 1 : 0);
      chk("ready", int'(req_ready),    (t >= d) ? 1 : 0);
      chk("done",  int'(done),         (t == d) ? 1 : 0);
      chk("cnt_valid", int'(cnt_valid), (FREQ && e && t == d) ? 1 : 0);
`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
      if (e && t == d) chk_rng("edge_cnt", int'(edge_cnt), exp_lo, exp_hi);
`else
      chk("edge_cnt", int'(edge_cnt), 0);
`endif
      if (t == inj_t) begin
        req_sel = 4'd5; req_ndiv = 3'd0; req_en = 1'b1; req_valid = 1'b1;
      end
      if (t == abort_t) begin
        #2 rstb = 1'b0;
        #1 chk_reset_vals("abort");
        cur_sel = 0; cur_ndiv = 0; cur_en = 0;
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("abort_ready", int'(req_ready), 1);
          chk("abort_done",  int'(done),      0);
          chk("abort_en",    int'(en_outbuff), 0);
        end
        return;
      end
    end
    cur_sel = s; cur_ndiv = nd; cur_en = e;
  endtask

  vec_t vecs[6];

  initial begin
    int S, sel_at, en_at, dn, inj;
    logic [3:0] rs;
    logic [2:0] rn;
    logic       re;
    logic [7:0] rst_cyc;

    vecs[0] = '{4'd3,  3'd2, 1'b1, 8'd4,  5,  9,  9};
    vecs[1] = '{4'd6,  3'd1, 1'b0, 8'd0,  2, -1,  2};
    vecs[2] = '{4'd9,  3'd7, 1'b1, 8'd1,  2,  3,  3};
    vecs[3] = '{4'd15, 3'd0, 1'b1, 8'd0,  2,  3,  3};
    vecs[4] = '{4'd0,  3'd5, 1'b0, 8'd7,  8, -1,  8};
    vecs[5] = '{4'd12, 3'd4, 1'b1, 8'd20, 21, 41, 41};

    n_vec = 0; n_bad = 0;
    cur_sel = 0; cur_ndiv = 0; cur_en = 0;
    exp_lo = 0; exp_hi = 0; mon_run = 1'b0;
    req_valid = 1'b0; req_sel = '0; req_ndiv = '0; req_en = 1'b0; settle_cycles = '0;

    rstb = 1'b0;
    #2 chk_reset_vals("reset");
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(req_ready), 1);

    for (int i = 0; i < 6; i++)
      do_req(vecs[i].sel, vecs[i].ndiv, vecs[i].en, vecs[i].settle,
             vecs[i].sel_at, vecs[i].en_at, vecs[i].done_at, -1, -1);

    // competing request during SETTLE (t = 7..12) must be dropped
    do_req(4'd10, 3'd3, 1'b1, 8'd6, 7, 13, 13, 9, -1);
    // reset while settling, then a clean request
    do_req(4'd7, 3'd6, 1'b1, 8'd10, 11, 21, 21, -1, 14);
    do_req(4'd2, 3'd1, 1'b1, 8'd2, 3, 5, 5, -1, -1);

`ifdef OUTBUFF_SEQ_FREQ_CHECK_EN
    mon_run = 1'b1; exp_lo = 127; exp_hi = 129;
    do_req(4'd3, 3'd2, 1'b1, 8'd4, 5, 9, 9, -1, -1);
    mon_run = 1'b0; exp_lo = 0; exp_hi = 0;
    #200;
    do_req(4'd4, 3'd1, 1'b1, 8'd2, 3, 5, 5, -1, -1);
    mon_run = 1'b1;
    do_req(4'd1, 3'd1, 1'b1, 8'd3, 4, 7, 7, -1, 307);
    exp_lo = 127; exp_hi = 129;
    do_req(4'd8, 3'd3, 1'b1, 8'd3, 4, 7, 7, -1, -1);
    mon_run = 1'b0; exp_lo = 0; exp_hi = 0;
    #200;
`endif

    for (int n = 0; n < 20; n++) begin
      rs = 4'($urandom);
      rn = 3'($urandom);
      re = 1'($urandom);
      rst_cyc = 8'($urandom_range(0, 12));
      S = (rst_cyc == 0) ? 1 : int'(rst_cyc);
      sel_at = S + 1;
      en_at = re ? 2 * S + 1 : -1;
      dn = re ? 2 * S + 1 : S + 1;
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, dn - 1)) : -1;
      do_req(rs, rn, re, rst_cyc, sel_at, en_at, dn, inj, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
